// File: rtl/branch_cmp_sched_if.sv
// Condition-op encoding plus the request/response bundle of the shared branch comparator.
// Encodings follow RISC-V funct3; 3'b010 and 3'b011 are unused and compare as not-taken.
package branch_cmp_pkg;
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } t_branch_cond_op;
endpackage

interface branch_cmp_sched_if #(parameter int TAG_W = 4) ();
  logic [1:0]                        req_valid;
  logic [1:0]                        req_ready;
  logic [31:0]                       req_rs1_0;
  logic [31:0]                       req_rs1_1;
  logic [31:0]                       req_rs2_0;
  logic [31:0]                       req_rs2_1;
  branch_cmp_pkg::t_branch_cond_op   req_op_0;
  branch_cmp_pkg::t_branch_cond_op   req_op_1;
  logic [TAG_W-1:0]                  req_tag_0;
  logic [TAG_W-1:0]                  req_tag_1;
  logic                              rsp_valid;
  logic                              rsp_ready;
  logic                              rsp_taken;
  logic                              rsp_src;
  logic [TAG_W-1:0]                  rsp_tag;

  modport master (
    output req_valid, req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1,
           req_op_0, req_op_1, req_tag_0, req_tag_1, rsp_ready,
    input  req_ready, rsp_valid, rsp_taken, rsp_src, rsp_tag
  );

  modport slave (
    input  req_valid, req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1,
           req_op_0, req_op_1, req_tag_0, req_tag_1, rsp_ready,
    output req_ready, rsp_valid, rsp_taken, rsp_src, rsp_tag
  );
endinterface

// File: rtl/branch_cmp_sched.sv
// Two requesters share one branch comparator through a round-robin arbiter;
// the result sits in a single register slot that can drain and reload every cycle.
module branch_cmp_sched
  import branch_cmp_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  branch_cmp_sched_if.slave   bus,
  output logic [15:0]         grant_cnt_0,
  output logic [15:0]         grant_cnt_1
);

  logic             rsp_valid_q;
  logic             rsp_taken_q;
  logic             rsp_src_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             prio;

  logic             slot_free;
  logic             can_accept;
  logic             winner;
  logic [1:0]       ready;
  logic             grant;
  logic [31:0]      sel_rs1;
  logic [31:0]      sel_rs2;
  t_branch_cond_op  sel_op;
  logic [TAG_W-1:0] sel_tag;
  logic             cmp_taken;

  // rst_n gates acceptance so nothing is offered while reset is held.
  assign slot_free  = !rsp_valid_q || bus.rsp_ready;
  assign can_accept = slot_free && !flush && rst_n;

  always_comb begin
    winner = 1'b0;
    ready  = 2'b00;
    if (bus.req_valid == 2'b11) begin
      winner = prio;
    end else if (bus.req_valid[1]) begin
      winner = 1'b1;
    end
    if (can_accept && (bus.req_valid != 2'b00)) begin
      ready = winner ? 2'b10 : 2'b01;
    end
  end

  assign grant         = |(bus.req_valid & ready);
  assign bus.req_ready = ready;

  assign sel_rs1 = winner ? bus.req_rs1_1 : bus.req_rs1_0;
  assign sel_rs2 = winner ? bus.req_rs2_1 : bus.req_rs2_0;
  assign sel_op  = winner ? bus.req_op_1  : bus.req_op_0;
  assign sel_tag = winner ? bus.req_tag_1 : bus.req_tag_0;

  always_comb begin
    cmp_taken = 1'b0;
    case (sel_op)
      BR_BEQ:  cmp_taken = (sel_rs1 == sel_rs2);
      BR_BNE:  cmp_taken = (sel_rs1 != sel_rs2);
      BR_BLT:  cmp_taken = ($signed(sel_rs1) <  $signed(sel_rs2));
      BR_BGE:  cmp_taken = ($signed(sel_rs1) >= $signed(sel_rs2));
      BR_BLTU: cmp_taken = (sel_rs1 <  sel_rs2);
      BR_BGEU: cmp_taken = (sel_rs1 >= sel_rs2);
      default: cmp_taken = 1'b0;
    endcase
  end

  // Flush wins over a drain; a grant reloads the slot even while it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_taken_q <= 1'b0;
      rsp_src_q   <= 1'b0;
      rsp_tag_q   <= '0;
      prio        <= 1'b0;
    end else if (flush) begin
      rsp_valid_q <= 1'b0;
    end else if (grant) begin
      rsp_valid_q <= 1'b1;
      rsp_taken_q <= cmp_taken;
      rsp_src_q   <= winner;
      rsp_tag_q   <= sel_tag;
      prio        <= !winner;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_0 <= 16'h0000;
      grant_cnt_1 <= 16'h0000;
    end else if (grant) begin
      if (!winner && (grant_cnt_0 != 16'hFFFF)) begin
        grant_cnt_0 <= grant_cnt_0 + 16'h0001;
      end
      if (winner && (grant_cnt_1 != 16'hFFFF)) begin
        grant_cnt_1 <= grant_cnt_1 + 16'h0001;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_taken = rsp_taken_q;
  assign bus.rsp_src   = rsp_src_q;
  assign bus.rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_branch_cmp_sched.sv
// Directed bench for branch_cmp_sched: each task drives one scenario and checks
// hand-computed responses one time unit after the rising edge.
module tb_branch_cmp_sched;
  import branch_cmp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] grant_cnt_0;
  logic [15:0] grant_cnt_1;
  int          checks = 0;
  int          errors = 0;

  branch_cmp_sched_if #(.TAG_W(4)) bus ();

  branch_cmp_sched #(.TAG_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus.slave),
    .grant_cnt_0 (grant_cnt_0),
    .grant_cnt_1 (grant_cnt_1)
  );

  always #5 clk = ~clk;

  // Packed view {valid, taken, src, tag} for compact response checks.
  wire [6:0] rsp = {bus.rsp_valid, bus.rsp_taken, bus.rsp_src, bus.rsp_tag};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int slot, input logic [31:0] rs1, input logic [31:0] rs2,
                         input t_branch_cond_op op, input logic [3:0] tag);
    if (slot == 0) begin
      bus.req_rs1_0 = rs1; bus.req_rs2_0 = rs2; bus.req_op_0 = op; bus.req_tag_0 = tag;
    end else begin
      bus.req_rs1_1 = rs1; bus.req_rs2_1 = rs2; bus.req_op_1 = op; bus.req_tag_1 = tag;
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b11;
    #1;
    checks++;
    if (rsp !== 7'h00) begin errors++; $display("[TB] FAIL reset_rsp got=%h exp=00", rsp); end
    checks++;
    if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=00", bus.req_ready); end
    checks++;
    if ({grant_cnt_0, grant_cnt_1} !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_cnt got=%h/%h exp=0/0", grant_cnt_0, grant_cnt_1);
    end
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    set_req(0, 32'h5, 32'h5, BR_BEQ, 4'h3);
    bus.req_valid = 2'b01;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_ready got=%b exp=01", bus.req_ready); end
    tick();
    checks++;
    if (rsp !== {1'b1, 1'b1, 1'b0, 4'h3}) begin errors++; $display("[TB] FAIL single_rsp got=%h exp=%h", rsp, {3'b110, 4'h3}); end
    checks++;
    if (grant_cnt_0 !== 16'd1) begin errors++; $display("[TB] FAIL single_cnt0 got=%0d exp=1", grant_cnt_0); end
    bus.req_valid = 2'b00;
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_signed();
    logic [31:0]     v_rs1 [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h1};
    logic [31:0]     v_rs2 [5] = '{32'h1, 32'h1, 32'h1, 32'h9, 32'hFFFFFFFF};
    t_branch_cond_op v_op  [5] = '{BR_BLT, BR_BLTU, BR_BGEU, t_branch_cond_op'(3'b010), BR_BGE};
    logic [1:0]      v_vld [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    logic [6:0]      v_exp [5] = '{7'b1_1_0_0100, 7'b1_0_0_0101, 7'b1_1_0_0110, 7'b1_0_0_0111, 7'b1_1_1_1000};
    for (int i = 0; i < 5; i++) begin
      set_req(i == 4 ? 1 : 0, v_rs1[i], v_rs2[i], v_op[i], 4'(i + 4));
      bus.req_valid = v_vld[i];
      tick();
      checks++;
      if (rsp !== v_exp[i]) begin errors++; $display("[TB] FAIL signed_%0d got=%b exp=%b", i, rsp, v_exp[i]); end
    end
    checks++;
    if ({grant_cnt_0, grant_cnt_1} !== {16'd5, 16'd1}) begin
      errors++; $display("[TB] FAIL signed_cnt got=%0d/%0d exp=5/1", grant_cnt_0, grant_cnt_1);
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ready [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [6:0] exp_rsp   [4] = '{7'b1_1_0_1010, 7'b1_0_1_1011, 7'b1_1_0_1010, 7'b1_0_1_1011};
    set_req(0, 32'h1, 32'h1, BR_BEQ, 4'hA);
    set_req(1, 32'h1, 32'h1, BR_BNE, 4'hB);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.req_ready !== exp_ready[i]) begin errors++; $display("[TB] FAIL rr_ready_%0d got=%b exp=%b", i, bus.req_ready, exp_ready[i]); end
      tick();
      checks++;
      if (rsp !== exp_rsp[i]) begin errors++; $display("[TB] FAIL rr_rsp_%0d got=%b exp=%b", i, rsp, exp_rsp[i]); end
    end
    checks++;
    if ({grant_cnt_0, grant_cnt_1} !== {16'd7, 16'd3}) begin
      errors++; $display("[TB] FAIL rr_cnt got=%0d/%0d exp=7/3", grant_cnt_0, grant_cnt_1);
    end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(0, 32'h2 + 32'(i), 32'h3 + 32'(i), BR_BLTU, 4'hC);
      set_req(1, 32'h0, 32'h1, BR_BGEU, 4'hD);
      #1;
      checks++;
      if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL bp_ready_%0d got=%b exp=00", i, bus.req_ready); end
      tick();
      checks++;
      if (rsp !== 7'b1_0_1_1011) begin errors++; $display("[TB] FAIL bp_hold_%0d got=%b exp=1011011", i, rsp); end
    end
    checks++;
    if ({grant_cnt_0, grant_cnt_1} !== {16'd7, 16'd3}) begin
      errors++; $display("[TB] FAIL bp_cnt got=%0d/%0d exp=7/3", grant_cnt_0, grant_cnt_1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL bp_release_ready got=%b exp=01", bus.req_ready); end
    tick();
    checks++;
    if (rsp !== 7'b1_1_0_1100) begin errors++; $display("[TB] FAIL bp_release_rsp got=%b exp=1101100", rsp); end
    checks++;
    if (grant_cnt_0 !== 16'd8) begin errors++; $display("[TB] FAIL bp_release_cnt0 got=%0d exp=8", grant_cnt_0); end
  endtask

  task automatic test_flush();
    bus.rsp_ready = 1'b0;
    flush         = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL flush_ready got=%b exp=00", bus.req_ready); end
    tick();
    flush = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got=%b exp=0", bus.rsp_valid); end
    checks++;
    if ({grant_cnt_0, grant_cnt_1} !== {16'd8, 16'd3}) begin
      errors++; $display("[TB] FAIL flush_cnt got=%0d/%0d exp=8/3", grant_cnt_0, grant_cnt_1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL flush_prio got=%b exp=10", bus.req_ready); end
    tick();
    checks++;
    if (rsp !== 7'b1_0_1_1101) begin errors++; $display("[TB] FAIL flush_after_rsp got=%b exp=1011101", rsp); end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_saturation();
    bus.req_valid = 2'b10;
    repeat (16'hFFFE - 16'd4) @(posedge clk);
    #1;
    checks++;
    if (grant_cnt_1 !== 16'hFFFE) begin errors++; $display("[TB] FAIL sat_preload got=%h exp=fffe", grant_cnt_1); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant_cnt_1 !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_%0d got=%h exp=ffff", i, grant_cnt_1); end
    end
    checks++;
    if (grant_cnt_0 !== 16'd8) begin errors++; $display("[TB] FAIL sat_cnt0 got=%0d exp=8", grant_cnt_0); end
  endtask

  task automatic test_reset_mid_hold();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b00;
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid got=%b exp=1", bus.rsp_valid); end
    #2;
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (rsp !== 7'h00) begin errors++; $display("[TB] FAIL async_rst_rsp got=%h exp=00", rsp); end
    checks++;
    if ({grant_cnt_0, grant_cnt_1} !== 32'h0) begin
      errors++; $display("[TB] FAIL async_rst_cnt got=%h/%h exp=0/0", grant_cnt_0, grant_cnt_1);
    end
    checks++;
    if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL async_rst_ready got=%b exp=00", bus.req_ready); end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_accept got=%b exp=0", bus.rsp_valid); end
    rst_n = 1'b1;
    set_req(0, 32'h7, 32'h8, BR_BNE, 4'h9);
    bus.req_valid = 2'b01;
    tick();
    checks++;
    if (rsp !== 7'b1_1_0_1001) begin errors++; $display("[TB] FAIL post_rst_rsp got=%b exp=1101001", rsp); end
    checks++;
    if (grant_cnt_0 !== 16'd1) begin errors++; $display("[TB] FAIL post_rst_cnt0 got=%0d exp=1", grant_cnt_0); end
    bus.req_valid = 2'b00;
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    set_req(0, 32'h0, 32'h0, BR_BEQ, 4'h0);
    set_req(1, 32'h0, 32'h0, BR_BEQ, 4'h0);
    test_reset();
    test_single();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_saturation();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_cmp_sched.md
BRANCH_CMP_SCHED -- requirements
Module: branch_cmp_sched

Interface
REQ-001 Parameter TAG_W, default 4: width of the per-request tag returned with the result.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 flush  in  1  kill: discards the held result and blocks acceptance in the same cycle.
REQ-005 req_valid  in  2  per-requester request valid; index 0 = slot A, index 1 = slot B.
REQ-006 req_ready  out  2  per-requester accept; a request is accepted when req_valid[i] && req_ready[i].
REQ-007 req_rs1_0, req_rs1_1  in  32 each  first operand per requester.
REQ-008 req_rs2_0, req_rs2_1  in  32 each  second operand per requester.
REQ-009 req_op_0, req_op_1  in  t_branch_cond_op each  condition select per requester.
REQ-010 req_tag_0, req_tag_1  in  TAG_W each  opaque tag per requester.
REQ-011 rsp_valid  out  1  result register holds a valid result.
REQ-012 rsp_ready  in  1  consumer accepts the result when rsp_valid && rsp_ready.
REQ-013 rsp_taken  out  1  branch condition outcome.
REQ-014 rsp_src  out  1  index of the requester that produced the result.
REQ-015 rsp_tag  out  TAG_W  tag of the winning request.
REQ-016 grant_cnt_0, grant_cnt_1  out  16 each  saturating count of accepted requests per requester.

Function
REQ-017 The block SHALL contain exactly one comparator, shared by both requesters.
REQ-018 Compare semantics: BEQ equal; BNE not equal; BLT/BGE signed 32-bit less-than / greater-or-equal; BLTU/BGEU unsigned; any other encoding gives taken = 0.
REQ-019 Slot free: free = !rsp_valid || rsp_ready.
REQ-020 req_ready SHALL be one-hot or zero, combinational, and SHALL be zero whenever flush = 1 or free = 0.
REQ-021 Arbitration: round-robin with a 1-bit priority pointer prio.
REQ-022 If only one requester is valid, it wins.
REQ-023 If both are valid, requester prio wins.
REQ-024 After any accepted grant, prio SHALL be set to the index of the loser, i.e. !winner.
REQ-025 prio SHALL NOT change in cycles without an accepted grant.
REQ-026 Latency: the comparison is made on the winner's inputs in the accept cycle; rsp_valid/rsp_taken/rsp_src/rsp_tag are registered and visible the next cycle (1-cycle latency).
REQ-027 Accept and drain in the same cycle (rsp_valid && rsp_ready && grant) SHALL load the new result with no bubble; full throughput is 1 result/cycle.
REQ-028 Backpressure: while rsp_valid && !rsp_ready, all rsp_* outputs SHALL hold stable and no request is accepted.
REQ-029 flush = 1 SHALL clear rsp_valid at the next edge regardless of rsp_ready; no grant occurs and prio and the counters are unchanged.
REQ-030 Requester inputs are sampled only in the accept cycle; later changes do not affect the held result.
REQ-031 grant_cnt_i SHALL increment by 1 on each accepted grant to requester i and saturate at 16'hFFFF.
REQ-032 A non-accepted request (req_valid without req_ready) has no side effect.

Reset
REQ-033 On rst_n low, asynchronously: rsp_valid=0, rsp_taken=0, rsp_src=0, rsp_tag=0, prio=0, grant_cnt_0=grant_cnt_1=0.
REQ-034 Reset asserted mid-transaction SHALL drop any held result; the first accept after release requires rst_n high at a rising edge.
REQ-035 req_ready SHALL be 0 while rst_n is low.

Verification
REQ-036 Single request: req_valid=01, op BEQ, rs1=rs2=0x5, tag=3, rsp_ready=1 -> next cycle rsp_valid=1, taken=1, src=0, tag=3; grant_cnt_0=1.
REQ-037 Signed vs unsigned: rs1=0xFFFFFFFF, rs2=0x1 -> BLT taken=1; BLTU taken=0; BGEU taken=1.
REQ-038 Contention: both valid for 4 cycles, rsp_ready=1, prio=0 at start -> grant order 0,1,0,1; back-to-back rsp_valid with no bubble.
REQ-039 Backpressure: rsp_ready=0 for 3 cycles with both requesters valid -> rsp_* held, req_ready=00, counters unchanged; rsp_ready=1 -> drain and accept in the same cycle.
REQ-040 Flush: rsp_valid=1, rsp_ready=0, flush=1 -> next cycle rsp_valid=0, prio unchanged, no grant in the flush cycle.
REQ-041 Saturation and reset: preload grant_cnt_1 to 0xFFFE, then 3 grants to 1 -> 0xFFFF; rst_n pulse mid-hold -> all outputs 0 immediately.
